// File: rtl/gate_access_if.sv
// Gate access controller bus: vehicle sensors, PIN keypad and operator
// button toward the controller; gate commands, alarms and attempt count back.
interface gate_access_if #(
    parameter int PIN_W     = 16,
    parameter int MAX_TRIES = 3
);
    localparam int TRIES_W = $clog2(MAX_TRIES + 1);

    // Stimulus side (sensors, keypad, operator panel)
    logic               vehicle_arrived;
    logic               vehicle_passed;
    logic               pin_valid;
    logic [PIN_W-1:0]   pin;
    logic               unlock_btn;

    // Controller side (gate actuator, alarms, attempt display)
    logic               gate_open;
    logic               gate_close;
    logic               alarm_wrong_pin;
    logic               alarm_block;
    logic [TRIES_W-1:0] tries_left;

    // Environment / testbench view: drives the sensors and keypad.
    modport master (
        output vehicle_arrived,
        output vehicle_passed,
        output pin_valid,
        output pin,
        output unlock_btn,
        input  gate_open,
        input  gate_close,
        input  alarm_wrong_pin,
        input  alarm_block,
        input  tries_left
    );

    // Controller view.
    modport slave (
        input  vehicle_arrived,
        input  vehicle_passed,
        input  pin_valid,
        input  pin,
        input  unlock_btn,
        output gate_open,
        output gate_close,
        output alarm_wrong_pin,
        output alarm_block,
        output tries_left
    );
endinterface

// File: rtl/gate_access_ctrl.sv
// Gate access controller: a vehicle arriving opens a PIN-entry window; a
// correct PIN opens the gate, too many wrong PINs or tailgating lock the
// gate until an operator unlocks it with the button plus the correct PIN.
// All outputs are registered and change on the edge that samples the cause.
module gate_access_ctrl #(
    parameter int               PIN_W         = 16,
    parameter logic [PIN_W-1:0] PIN_OK        = PIN_W'(16'h1194),
    parameter int               MAX_TRIES     = 3,
    parameter int               ENTRY_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    gate_access_if.slave  bus
);
    localparam int TRIES_W = $clog2(MAX_TRIES + 1);
    localparam int TIMER_W = $clog2(ENTRY_TIMEOUT + 1);

    localparam logic [TRIES_W-1:0] TRIES_MAX   = TRIES_W'(MAX_TRIES);
    localparam logic [TRIES_W-1:0] TRIES_ONE   = TRIES_W'(1);
    localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(ENTRY_TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_SAT   = {TIMER_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_OPEN,
        ST_BLOCK
    } state_e;

    state_e               state_q, state_d;
    logic [TRIES_W-1:0]   tries_q, tries_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 gate_open_q, gate_open_d;
    logic                 gate_close_q, gate_close_d;
    logic                 wrong_pin_q, wrong_pin_d;
    logic                 alarm_block_q, alarm_block_d;

    logic                 pin_match;
    logic                 pin_good;
    logic                 pin_bad;
    logic [TIMER_W-1:0]   timer_inc;

    // Full-width PIN equality, qualified by the strobe.
    assign pin_match = (bus.pin == PIN_OK);
    assign pin_good  = bus.pin_valid &&  pin_match;
    assign pin_bad   = bus.pin_valid && !pin_match;

    // Entry timer increment that sticks at all-ones instead of wrapping.
    assign timer_inc = (timer_q == TIMER_SAT) ? timer_q : timer_q + TIMER_W'(1);

    // Next-state, attempt counter, entry timer and registered-output decode.
    // NOTE: every signal written here gets a default first, so no branch
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        tries_d      = tries_q;
        timer_d      = timer_q;
        gate_close_d = 1'b0;
        wrong_pin_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // PIN strobes are meaningless without a vehicle waiting.
                if (bus.vehicle_arrived) begin
                    state_d = ST_ENTRY;
                    tries_d = TRIES_MAX;
                    timer_d = '0;
                end
            end

            ST_ENTRY: begin
                if (pin_good) begin
                    state_d = ST_OPEN;
                    tries_d = TRIES_MAX;
                    timer_d = '0;
                end else if (pin_bad) begin
                    // A wrong PIN always alarms and gives the driver a
                    // fresh timeout window; the last allowed one locks out.
                    wrong_pin_d = 1'b1;
                    timer_d     = '0;
                    if (tries_q <= TRIES_ONE) begin
                        tries_d = '0;
                        state_d = ST_BLOCK;
                    end else begin
                        tries_d = tries_q - TRIES_ONE;
                    end
                end else if (timer_inc >= TIMER_LIMIT) begin
                    // Driver gave up: abandon quietly.
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_inc;
                end
            end

            ST_OPEN: begin
                // Stay open until the exit sensor clears; a second vehicle
                // at the entry sensor at that moment is tailgating.
                if (bus.vehicle_passed) begin
                    gate_close_d = 1'b1;
                    state_d      = bus.vehicle_arrived ? ST_BLOCK : ST_IDLE;
                end
            end

            ST_BLOCK: begin
                // Only the operator, with the correct PIN, clears a lockout.
                if (bus.unlock_btn && pin_good) begin
                    state_d = ST_IDLE;
                    tries_d = TRIES_MAX;
                end
            end

            default: begin
                state_d = ST_IDLE;
                tries_d = TRIES_MAX;
                timer_d = '0;
            end
        endcase

        // Level outputs are decoded from the next state so that the
        // registered copy tracks the state register exactly.
        gate_open_d   = (state_d == ST_OPEN);
        alarm_block_d = (state_d == ST_BLOCK);
    end

    // State, counters and registered outputs; reset aborts any activity.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            tries_q       <= TRIES_MAX;
            timer_q       <= '0;
            gate_open_q   <= 1'b0;
            gate_close_q  <= 1'b0;
            wrong_pin_q   <= 1'b0;
            alarm_block_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tries_q       <= tries_d;
            timer_q       <= timer_d;
            gate_open_q   <= gate_open_d;
            gate_close_q  <= gate_close_d;
            wrong_pin_q   <= wrong_pin_d;
            alarm_block_q <= alarm_block_d;
        end
    end

    assign bus.gate_open       = gate_open_q;
    assign bus.gate_close      = gate_close_q;
    assign bus.alarm_wrong_pin = wrong_pin_q;
    assign bus.alarm_block     = alarm_block_q;
    assign bus.tries_left      = tries_q;

    // Structural invariants of the controller.
    a_tries_bounded : assert property (@(posedge clk) disable iff (reset)
        tries_q <= TRIES_MAX);
    a_open_tracks_state : assert property (@(posedge clk) disable iff (reset)
        gate_open_q == (state_q == ST_OPEN));
    a_block_tracks_state : assert property (@(posedge clk) disable iff (reset)
        alarm_block_q == (state_q == ST_BLOCK));
    a_timer_bounded : assert property (@(posedge clk) disable iff (reset)
        timer_q < TIMER_LIMIT);
endmodule

// File: tb/tb_gate_access_ctrl.sv
// Directed testbench for gate_access_ctrl with default parameters.
// Outputs are sampled 1 time unit after the rising edge; the observed
// vector is {gate_open, gate_close, alarm_wrong_pin, alarm_block, tries_left}.
module tb_gate_access_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    gate_access_if #(.PIN_W(16), .MAX_TRIES(3)) bus ();

    gate_access_ctrl #(
        .PIN_W         (16),
        .PIN_OK        (16'h1194),
        .MAX_TRIES     (3),
        .ENTRY_TIMEOUT (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Expected output vectors {open, close, wrong, block, tries[1:0]}
    localparam logic [5:0] QUIET3  = 6'b000011;
    localparam logic [5:0] OPEN3   = 6'b100011;
    localparam logic [5:0] CLOSE3  = 6'b010011;
    localparam logic [5:0] WRONG2  = 6'b001010;
    localparam logic [5:0] QUIET2  = 6'b000010;
    localparam logic [5:0] WRONG1  = 6'b001001;
    localparam logic [5:0] QUIET1  = 6'b000001;
    localparam logic [5:0] LOCK0   = 6'b001100;
    localparam logic [5:0] BLOCK0  = 6'b000100;
    localparam logic [5:0] TAIL3   = 6'b010111;
    localparam logic [5:0] BLOCK3  = 6'b000111;

    function automatic logic [5:0] outs();
        return {bus.gate_open, bus.gate_close, bus.alarm_wrong_pin,
                bus.alarm_block, bus.tries_left};
    endfunction

    task automatic drive(input logic arr, input logic passed, input logic pv,
                         input logic [15:0] p, input logic unlock);
        bus.vehicle_arrived = arr;
        bus.vehicle_passed  = passed;
        bus.pin_valid       = pv;
        bus.pin             = p;
        bus.unlock_btn      = unlock;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] got;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        got = outs(); checks++;
        if (got !== QUIET3) begin errors++; $display("FAIL reset_state: got %b expected %b", got, QUIET3); end
        // Arrival held across release: nothing may move before the next edge.
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        #2 reset = 1'b0;
        #1;
        got = outs(); checks++;
        if (got !== QUIET3) begin errors++; $display("FAIL reset_release: got %b expected %b", got, QUIET3); end
        // Now go back to IDLE cleanly for the following tests.
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        #1 reset = 1'b0;
        tick();
    endtask

    task automatic test_idle_ignores_pin();
        logic [5:0] got;
        drive(1'b0, 1'b0, 1'b1, 16'h1194, 1'b0); tick();
        got = outs(); checks++;
        if (got !== QUIET3) begin errors++; $display("FAIL idle_good_pin: got %b expected %b", got, QUIET3); end
        drive(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0); tick();
        got = outs(); checks++;
        if (got !== QUIET3) begin errors++; $display("FAIL idle_bad_pin: got %b expected %b", got, QUIET3); end
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0); tick();
    endtask

    task automatic test_happy_path();
        logic [5:0] got;
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0); tick();
        got = outs(); checks++;
        if (got !== QUIET3) begin errors++; $display("FAIL happy_arrive: got %b expected %b", got, QUIET3); end
        drive(1'b0, 1'b0, 1'b1, 16'h1194, 1'b0); tick();
        got = outs(); checks++;
        if (got !== OPEN3) begin errors++; $display("FAIL happy_open: got %b expected %b", got, OPEN3); end
        // Wrong PIN in OPEN is ignored, gate holds with no timeout.
        drive(1'b0, 1'b0, 1'b1, 16'h0001, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0); repeat (20) tick();
        got = outs(); checks++;
        if (got !== OPEN3) begin errors++; $display("FAIL happy_hold_open: got %b expected %b", got, OPEN3); end
        drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0); tick();
        got = outs(); checks++;
        if (got !== CLOSE3) begin errors++; $display("FAIL happy_close: got %b expected %b", got, CLOSE3); end
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0); tick();
        got = outs(); checks++;
        if (got !== QUIET3) begin errors++; $display("FAIL happy_idle: got %b expected %b", got, QUIET3); end
    endtask

    task automatic test_lockout();
        logic [5:0] got;
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0); tick();
        got = outs(); checks++;
        if (got !== WRONG2) begin errors++; $display("FAIL lock_pin1: got %b expected %b", got, WRONG2); end
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0); tick();
        got = outs(); checks++;
        if (got !== QUIET2) begin errors++; $display("FAIL lock_pulse1_end: got %b expected %b", got, QUIET2); end
        drive(1'b0, 1'b0, 1'b1, 16'h1111, 1'b0); tick();
        got = outs(); checks++;
        if (got !== WRONG1) begin errors++; $display("FAIL lock_pin2: got %b expected %b", got, WRONG1); end
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0); tick();
        got = outs(); checks++;
        if (got !== QUIET1) begin errors++; $display("FAIL lock_pulse2_end: got %b expected %b", got, QUIET1); end
        drive(1'b0, 1'b0, 1'b1, 16'h2222, 1'b0); tick();
        got = outs(); checks++;
        if (got !== LOCK0) begin errors++; $display("FAIL lock_pin3: got %b expected %b", got, LOCK0); end
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0); tick();
        got = outs(); checks++;
        if (got !== BLOCK0) begin errors++; $display("FAIL lock_hold: got %b expected %b", got, BLOCK0); end
    endtask

    task automatic test_unlock();
        logic [5:0] got;
        // Wrong PIN in BLOCK: no alarm, no counter change.
        drive(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0); tick();
        got = outs(); checks++;
        if (got !== BLOCK0) begin errors++; $display("FAIL unlock_wrong_ignored: got %b expected %b", got, BLOCK0); end
        drive(1'b0, 1'b0, 1'b1, 16'h1234, 1'b1); tick();
        got = outs(); checks++;
        if (got !== BLOCK0) begin errors++; $display("FAIL unlock_bad_pin: got %b expected %b", got, BLOCK0); end
        // Correct PIN without the button is not enough.
        drive(1'b0, 1'b0, 1'b1, 16'h1194, 1'b0); tick();
        got = outs(); checks++;
        if (got !== BLOCK0) begin errors++; $display("FAIL unlock_no_button: got %b expected %b", got, BLOCK0); end
        // Button with one-bit-off PIN (full-width compare).
        drive(1'b0, 1'b0, 1'b1, 16'h9194, 1'b1); tick();
        got = outs(); checks++;
        if (got !== BLOCK0) begin errors++; $display("FAIL unlock_msb_diff: got %b expected %b", got, BLOCK0); end
        drive(1'b0, 1'b0, 1'b1, 16'h1194, 1'b1); tick();
        got = outs(); checks++;
        if (got !== QUIET3) begin errors++; $display("FAIL unlock_ok: got %b expected %b", got, QUIET3); end
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0); tick();
    endtask

    task automatic test_timeout();
        logic [5:0] got;
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0); repeat (16) tick();
        got = outs(); checks++;
        if (got !== QUIET3) begin errors++; $display("FAIL timeout_quiet: got %b expected %b", got, QUIET3); end
        // Back in IDLE, so a correct PIN must not open the gate.
        drive(1'b0, 1'b0, 1'b1, 16'h1194, 1'b0); tick();
        got = outs(); checks++;
        if (got !== QUIET3) begin errors++; $display("FAIL timeout_idle: got %b expected %b", got, QUIET3); end
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0); tick();
    endtask

    task automatic test_timeout_pin_priority();
        logic [5:0] got;
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0); repeat (15) tick();
        drive(1'b0, 1'b0, 1'b1, 16'h1194, 1'b0); tick();
        got = outs(); checks++;
        if (got !== OPEN3) begin errors++; $display("FAIL timeout_pin_priority: got %b expected %b", got, OPEN3); end
        drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0); tick();
    endtask

    task automatic test_wrong_pin_restarts_timer();
        logic [5:0] got;
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0); repeat (10) tick();
        drive(1'b0, 1'b0, 1'b1, 16'h1195, 1'b0); tick();
        got = outs(); checks++;
        if (got !== WRONG2) begin errors++; $display("FAIL restart_wrong: got %b expected %b", got, WRONG2); end
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0); repeat (15) tick();
        drive(1'b0, 1'b0, 1'b1, 16'h1194, 1'b0); tick();
        got = outs(); checks++;
        if (got !== OPEN3) begin errors++; $display("FAIL restart_open: got %b expected %b", got, OPEN3); end
        drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0); tick();
    endtask

    task automatic test_tailgate();
        logic [5:0] got;
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b1, 16'h1194, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0); tick();
        got = outs(); checks++;
        if (got !== TAIL3) begin errors++; $display("FAIL tailgate_close: got %b expected %b", got, TAIL3); end
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0); tick();
        got = outs(); checks++;
        if (got !== BLOCK3) begin errors++; $display("FAIL tailgate_block: got %b expected %b", got, BLOCK3); end
    endtask

    task automatic test_reset_mid_block();
        logic [5:0] got;
        // Lock out with tries_left=0 so the reset reload is visible.
        drive(1'b0, 1'b0, 1'b1, 16'h1194, 1'b1); tick();
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 16'(i), 1'b0); tick();
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        got = outs(); checks++;
        if (got !== LOCK0) begin errors++; $display("FAIL rst_block_setup: got %b expected %b", got, LOCK0); end
        #2 reset = 1'b1;
        #1;
        got = outs(); checks++;
        if (got !== QUIET3) begin errors++; $display("FAIL rst_block_async: got %b expected %b", got, QUIET3); end
        #2 reset = 1'b0;
        tick();
        got = outs(); checks++;
        if (got !== QUIET3) begin errors++; $display("FAIL rst_block_after: got %b expected %b", got, QUIET3); end
    endtask

    task automatic test_reset_mid_entry();
        logic [5:0] got;
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        #2 reset = 1'b1;
        #1;
        got = outs(); checks++;
        if (got !== QUIET3) begin errors++; $display("FAIL rst_entry_async: got %b expected %b", got, QUIET3); end
        #2 reset = 1'b0;
        // ENTRY was aborted: a correct PIN now is ignored in IDLE.
        drive(1'b0, 1'b0, 1'b1, 16'h1194, 1'b0); tick();
        got = outs(); checks++;
        if (got !== QUIET3) begin errors++; $display("FAIL rst_entry_idle: got %b expected %b", got, QUIET3); end
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0); tick();
    endtask

    initial begin
        test_reset();
        test_idle_ignores_pin();
        test_happy_path();
        test_lockout();
        test_unlock();
        test_timeout();
        test_timeout_pin_priority();
        test_wrong_pin_restarts_timer();
        test_tailgate();
        test_reset_mid_block();
        test_reset_mid_entry();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Bound the whole run in case the bench or DUT stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/gate_access_ctrl.md
GATE_ACCESS_CTRL -- requirements
Module: gate_access_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- PIN_W, 16, PIN width in bits.
- PIN_OK, 16'h1194, correct PIN value, PIN_W bits.
- MAX_TRIES, 3, wrong PINs allowed before lockout; legal range >= 1.
- ENTRY_TIMEOUT, 16, clk cycles without a PIN in ENTRY before abandoning; legal range >= 1.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning); clk is the clock, and reset is asynchronous and active-high:
- clk, in, 1, clock.
- reset, in, 1, asynchronous active-high reset.
- vehicle_arrived, in, 1, vehicle present at entry sensor (level).
- vehicle_passed, in, 1, vehicle cleared exit sensor (level).
- pin_valid, in, 1, one-cycle strobe qualifying pin.
- pin, in, PIN_W, entered PIN; sampled only when pin_valid=1.
- unlock_btn, in, 1, operator unlock request (level).
- gate_open, out, 1, gate open command (level while OPEN).
- gate_close, out, 1, one-cycle close pulse.
- alarm_wrong_pin, out, 1, one-cycle pulse per rejected PIN.
- alarm_block, out, 1, lockout alarm (level while BLOCK).
- tries_left, out, $clog2(MAX_TRIES+1), remaining attempts.

Function
REQ-003 The block SHALL use four states: IDLE, ENTRY, OPEN and BLOCK; all outputs SHALL be registered, updating on the clk edge that samples the causing inputs.
REQ-004 In IDLE, vehicle_arrived=1 SHALL move the block to ENTRY, reload tries_left=MAX_TRIES and clear the entry timer; pin_valid SHALL be ignored in IDLE.
REQ-005 In ENTRY, pin_valid=1 with pin==PIN_OK SHALL move the block to OPEN and reload tries_left=MAX_TRIES.
REQ-006 In ENTRY, pin_valid=1 with pin!=PIN_OK SHALL pulse alarm_wrong_pin for 1 cycle, decrement tries_left and restart the entry timer.
REQ-007 When a wrong PIN takes tries_left to 0, the block SHALL enter BLOCK on that same edge, and alarm_wrong_pin SHALL still pulse.
REQ-008 The entry timer SHALL count clk cycles in ENTRY while pin_valid=0; on reaching ENTRY_TIMEOUT the block SHALL return to IDLE with no alarm.
REQ-009 If pin_valid=1 on the cycle the timer expires, the PIN SHALL take priority over the timeout.
REQ-010 gate_open SHALL be 1 exactly while the state is OPEN and 0 in every other state.
REQ-011 In OPEN, vehicle_passed=1 with vehicle_arrived=0 SHALL move the block to IDLE and pulse gate_close for 1 cycle.
REQ-012 In OPEN, vehicle_passed=1 with vehicle_arrived=1 (tailgating) SHALL move the block to BLOCK and pulse gate_close for 1 cycle.
REQ-013 In OPEN, pin_valid SHALL be ignored, and the block SHALL hold OPEN while vehicle_passed=0; OPEN has no timeout.
REQ-014 alarm_block SHALL be 1 exactly while the state is BLOCK.
REQ-015 The block SHALL leave BLOCK only when unlock_btn=1 AND pin_valid=1 AND pin==PIN_OK in the same cycle, going to IDLE with tries_left=MAX_TRIES.
REQ-016 In BLOCK, wrong PINs SHALL be ignored: no alarm_wrong_pin pulse and no change to tries_left.
REQ-017 tries_left SHALL never wrap below 0 or exceed MAX_TRIES.
REQ-018 The entry timer SHALL be $clog2(ENTRY_TIMEOUT+1) bits wide and SHALL saturate rather than wrap.
REQ-019 All PIN comparisons SHALL be full PIN_W-bit equality.

Reset
REQ-020 reset=1 SHALL asynchronously force state=IDLE, gate_open=0, gate_close=0, alarm_wrong_pin=0, alarm_block=0, tries_left=MAX_TRIES and entry timer=0.
REQ-021 Asserting reset mid-operation in ENTRY, OPEN or BLOCK SHALL abort immediately; BLOCK SHALL NOT survive reset.
REQ-022 After reset deassertion, the first state transition SHALL occur no earlier than the next rising clk edge.

Verification
REQ-023 The bench SHALL cover, with default parameters:
- Happy path: arrive; pin 16'h1194 -> gate_open=1 next cycle; vehicle_passed=1, vehicle_arrived=0 -> gate_close pulse, IDLE, gate_open=0.
- Lockout: arrive; pins 16'h0000, 16'h1111, 16'h2222 -> three alarm_wrong_pin pulses, tries_left 2,1,0, alarm_block=1 after the 3rd pin.
- Unlock: in BLOCK, unlock_btn=1 with pin 16'h1234 -> remains BLOCK; unlock_btn=1 with pin 16'h1194 -> IDLE, tries_left=3.
- Timeout: arrive, no pin for 16 cycles -> IDLE, no alarms; a correct pin on cycle 16 -> OPEN.
- Tailgate: in OPEN, vehicle_passed=1 and vehicle_arrived=1 -> gate_close pulse, alarm_block=1.
- Reset mid-BLOCK: assert reset between clock edges -> all outputs 0 and tries_left=3 immediately.
